// File: rtl/floppy_pkg.sv
// Shared floppy-bus constants, head state type and the track clamp helper.
package floppy_pkg;

    localparam int   MAX_TRACK_DEFAULT = 79;
    localparam int   TRACK_W           = 7;
    localparam logic BUS_ASSERT        = 1'b0;
    localparam logic BUS_IDLE          = ~BUS_ASSERT;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } head_state_e;

    // Move the head one track, saturating at track 0 and at max_trk.
    function automatic logic [TRACK_W-1:0] next_track(
        input logic [TRACK_W-1:0] cur,
        input logic               inward,
        input logic [TRACK_W-1:0] max_trk
    );
        if (inward) begin
            return (cur >= max_trk) ? cur : cur + TRACK_W'(1);
        end
        return (cur == '0) ? cur : cur - TRACK_W'(1);
    endfunction

endpackage

// File: rtl/index_gen.sv
// Revolution counter and active-low index pulse.
// The counter runs only while the motor is on; selection only masks the output.
module index_gen
    import floppy_pkg::*;
#(
    parameter int INDEX_PERIOD = 2400000,
    parameter int INDEX_WIDTH  = 48000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic motor_on,
    input  logic selected,
    output logic index
);

    localparam int CNT_W = (INDEX_PERIOD > 1) ? $clog2(INDEX_PERIOD) : 1;

    logic [CNT_W-1:0] rev_cnt_q;
    logic [CNT_W-1:0] rev_cnt_d;

    // Next count: wrap at the end of a revolution, clear while the motor is off.
    always_comb begin
        rev_cnt_d = '0;
        if (motor_on) begin
            rev_cnt_d = (rev_cnt_q == CNT_W'(INDEX_PERIOD - 1)) ? '0 : rev_cnt_q + CNT_W'(1);
        end
    end

    // Revolution counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rev_cnt_q <= '0;
        end else begin
            rev_cnt_q <= rev_cnt_d;
        end
    end

    // Gating by motor_on makes the output go inactive in the same cycle the motor stops.
    assign index = (motor_on && selected && (int'(rev_cnt_q) < INDEX_WIDTH)) ? BUS_ASSERT : BUS_IDLE;

endmodule

// File: rtl/step_responder.sv
// Floppy drive head stepper emulation: synchronizes the host bus, accepts step
// strobes, tracks head position with clamping and holds busy while settling.
// Optional index pulse generator enabled by defining FLOPPY_INDEX_GEN_EN.
module step_responder
    import floppy_pkg::*;
#(
    parameter int MAX_TRACK    = MAX_TRACK_DEFAULT,
    parameter int STEP_SETTLE  = 60000,
    parameter int INDEX_PERIOD = 2400000,
    parameter int INDEX_WIDTH  = 48000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step_n,
    input  logic               dir_n,
    input  logic               sel_n,
    input  logic               motor_n,
    output logic               track_0,
    output logic               index,
    output logic [TRACK_W-1:0] track,
    output logic               step_pulse,
    output logic               busy
);

    localparam int NSYNC      = 4;
    localparam int SYNC_STEP  = 0;
    localparam int SYNC_DIR   = 1;
    localparam int SYNC_SEL   = 2;
    localparam int SYNC_MOTOR = 3;
    localparam int SETTLE_W   = $clog2(STEP_SETTLE + 1);

    logic [NSYNC-1:0]    raw_in;
    logic [NSYNC-1:0]    meta_q;
    logic [NSYNC-1:0]    sync_q;
    logic                step_prev_q;
    logic                step_edge;
    logic                selected;
    logic                motor_sync;

    head_state_e         state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [TRACK_W-1:0]  track_q, track_d;
    logic                step_pulse_q, step_pulse_d;

    assign raw_in = {motor_n, sel_n, dir_n, step_n};

    // Two-flop synchronizers; reset to the inactive bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q      <= '1;
            sync_q      <= '1;
            step_prev_q <= 1'b1;
        end else begin
            meta_q      <= raw_in;
            sync_q      <= meta_q;
            step_prev_q <= sync_q[SYNC_STEP];
        end
    end

    assign selected   = (sync_q[SYNC_SEL] == BUS_ASSERT);
    assign motor_sync = sync_q[SYNC_MOTOR];
    assign step_edge  = step_prev_q && (sync_q[SYNC_STEP] == BUS_ASSERT) && selected;

    // Head FSM: accept a step in IDLE, then stay in SETTLE for STEP_SETTLE cycles.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        track_d      = track_q;
        step_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (step_edge) begin
                    track_d      = next_track(track_q, sync_q[SYNC_DIR] == BUS_ASSERT,
                                              TRACK_W'(MAX_TRACK));
                    step_pulse_d = 1'b1;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_W'(STEP_SETTLE - 1)) begin
                    state_d = IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Head state, settle timer, position and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            track_q      <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            track_q      <= track_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign track      = track_q;
    assign step_pulse = step_pulse_q;
    assign busy       = (state_q == SETTLE);
    assign track_0    = ((track_q == '0) && selected) ? BUS_ASSERT : BUS_IDLE;

`ifdef FLOPPY_INDEX_GEN_EN
    index_gen #(
        .INDEX_PERIOD(INDEX_PERIOD),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_index_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .motor_on(motor_sync == BUS_ASSERT),
        .selected(selected),
        .index   (index)
    );
`else
    // Index permanently inactive; the extra terms fold to a constant high and
    // only keep the motor synchronizer and index timing parameters referenced.
    assign index = BUS_IDLE | motor_sync | (INDEX_WIDTH >= INDEX_PERIOD);
`endif

endmodule
